path_result_buffer: RTL and testbench

- Downstream consumer of the Path datapath's 9-bit result `y`.
- Captures each valid result together with its 4-bit `op` tag into a small FIFO.
- Presents results to the next stage over a valid/ready handshake.
- Path has no backpressure, so this block absorbs bursts and flags any result it has to drop.

---
 rtl/path_pkg.sv | 23 ++
 rtl/path_result_buffer_if.sv | 25 ++
 rtl/path_result_mem.sv | 24 ++
 rtl/path_result_buffer.sv | 89 ++++++++
 tb/tb_path_result_buffer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/path_pkg.sv
// Types and constants shared between the Path datapath and its result buffer.
package path_pkg;

  localparam int DATA_W = 9;
  localparam int OP_W   = 4;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] y;
  } path_result_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_PASS = 4'h7
  } path_op_e;

endpackage

// File: rtl/path_result_buffer_if.sv
// Result channel into and out of path_result_buffer: Path-side capture plus
// the downstream valid/ready handshake.
interface path_result_buffer_if #(
  parameter int DATA_W = path_pkg::DATA_W,
  parameter int OP_W   = path_pkg::OP_W
);
  logic              in_valid;
  logic [DATA_W-1:0] in_y;
  logic [OP_W-1:0]   in_op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic [OP_W-1:0]   out_op;
  logic              out_carry;

  modport master (
    output in_valid, in_y, in_op, out_ready,
    input  out_valid, out_y, out_op, out_carry
  );

  modport slave (
    input  in_valid, in_y, in_op, out_ready,
    output out_valid, out_y, out_op, out_carry
  );
endinterface

// File: rtl/path_result_mem.sv
// Result storage: DEPTH entries, synchronous write, asynchronous read, no reset.
module path_result_mem
  import path_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  path_result_t wdata,
  input  logic [AW-1:0] raddr,
  output path_result_t rdata
);

  path_result_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/path_result_buffer.sv
// FWFT result FIFO behind Path; drops and flags results when full with no pop.
// Optional saturating statistics counters under PATH_RESULT_STATS_EN.
module path_result_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = path_pkg::DATA_W,
  parameter int OP_W   = path_pkg::OP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  path_result_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    ovf_err,
  input  logic                    clr_err
`ifdef PATH_RESULT_STATS_EN
  ,
  output logic [15:0]             stat_total,
  output logic [15:0]             stat_carry,
  output logic [7:0]              stat_drop
`endif
);
  import path_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, drop;
  path_result_t  wr_entry, rd_entry;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = !empty && bus.out_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push  = bus.in_valid && (!full || pop);
  assign drop  = bus.in_valid && !push;

  assign wr_entry = '{op: bus.in_op, y: bus.in_y};

  path_result_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Storage is unreset, so mask the head while empty to keep outputs at zero.
  always_comb begin
    bus.out_valid = !empty;
    bus.out_y     = empty ? DATA_W'(0) : rd_entry.y;
    bus.out_op    = empty ? OP_W'(0)   : rd_entry.op;
    bus.out_carry = bus.out_y[DATA_W-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop)         ovf_err <= 1'b1;
      else if (clr_err) ovf_err <= 1'b0;
    end
  end

`ifdef PATH_RESULT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_total <= '0;
      stat_carry <= '0;
      stat_drop  <= '0;
    end else begin
      if (push && stat_total != '1) stat_total <= stat_total + 16'd1;
      if (push && bus.in_y[DATA_W-1] && stat_carry != '1)
        stat_carry <= stat_carry + 16'd1;
      if (drop && stat_drop != '1) stat_drop <= stat_drop + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_path_result_buffer.sv
// Bench for path_result_buffer: directed scenarios plus random traffic against
// a queue-based model. Stats checks compile in with PATH_RESULT_STATS_EN.
module tb_path_result_buffer;
  localparam int DEPTH = 8;
  localparam int DW    = 9;
  localparam int OW    = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr_err = 1'b0;
  logic [CW-1:0] count;
  logic          full, empty, ovf_err;
`ifdef PATH_RESULT_STATS_EN
  logic [15:0]   stat_total, stat_carry;
  logic [7:0]    stat_drop;
`endif

  path_result_buffer_if #(.DATA_W(DW), .OP_W(OW)) bus ();

  path_result_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .OP_W(OW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .ovf_err (ovf_err),
    .clr_err (clr_err)
`ifdef PATH_RESULT_STATS_EN
    ,
    .stat_total (stat_total),
    .stat_carry (stat_carry),
    .stat_drop  (stat_drop)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: queue of {op, y}, sticky error, stat counters.
  logic [12:0]  q[$];
  bit           m_ovf  = 1'b0;
  int unsigned  m_tot  = 0;
  int unsigned  m_car  = 0;
  int unsigned  m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [12:0] h;
    h = (q.size() != 0) ? q[0] : 13'h0;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("out_y",     32'(bus.out_y),     32'(h[8:0]));
    chk("out_op",    32'(bus.out_op),    32'(h[12:9]));
    chk("out_carry", 32'(bus.out_carry), 32'(h[8]));
    chk("count",     32'(count),         32'(q.size()));
    chk("full",      32'(full),          32'(q.size() == DEPTH));
    chk("empty",     32'(empty),         32'(q.size() == 0));
    chk("ovf_err",   32'(ovf_err),       32'(m_ovf));
`ifdef PATH_RESULT_STATS_EN
    chk("stat_total", 32'(stat_total), m_tot);
    chk("stat_carry", 32'(stat_carry), m_car);
    chk("stat_drop",  32'(stat_drop),  m_drop);
`endif
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input bit r, input bit iv, input logic [8:0] y,
                      input logic [3:0] op, input bit rdy, input bit clr);
    bit pop, acc, drp;
    rst = r;
    bus.in_valid = iv;
    bus.in_y = y;
    bus.in_op = op;
    bus.out_ready = rdy;
    clr_err = clr;
    if (!r) begin
      q.delete();
      m_ovf = 1'b0;
      m_tot = 0;
      m_car = 0;
      m_drop = 0;
    end else begin
      pop = rdy && (q.size() > 0);
      acc = iv && ((q.size() < DEPTH) || pop);
      drp = iv && !acc;
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back({op, y});
        if (m_tot < 16'hFFFF) m_tot++;
        if (y[8] && m_car < 16'hFFFF) m_car++;
      end
      if (drp) begin
        m_ovf = 1'b1;
        if (m_drop < 8'hFF) m_drop++;
      end else if (clr) begin
        m_ovf = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit rdy);
    step(1'b1, 1'b0, 9'h0, 4'h0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 9'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 9'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [8:0] y;
    bus.in_valid = 1'b0;
    bus.in_y = '0;
    bus.in_op = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset release
    do_reset();
    idle(1'b0);
    chk("s1_empty", 32'(empty), 32'd1);
    chk("s1_count", 32'(count), 32'd0);

    // Single pass-through
    step(1'b1, 1'b1, 9'h0FF, 4'h0, 1'b0, 1'b0);
    chk("s2_y", 32'(bus.out_y), 32'h0FF);
    chk("s2_count", 32'(count), 32'd1);
    idle(1'b1);
    chk("s2_empty", 32'(empty), 32'd1);

    // Fill then drop
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      y = 9'h100 + 9'(i);
      step(1'b1, 1'b1, y, 4'(i), 1'b0, 1'b0);
    end
    chk("s3_full", 32'(full), 32'd1);
    chk("s3_carry", 32'(bus.out_carry), 32'd1);
    step(1'b1, 1'b1, 9'h1AA, 4'hA, 1'b0, 1'b0);
    chk("s3_ovf", 32'(ovf_err), 32'd1);
    chk("s3_count", 32'(count), 32'd8);
`ifdef PATH_RESULT_STATS_EN
    chk("s7_total", 32'(stat_total), 32'd8);
    chk("s7_carry", 32'(stat_carry), 32'd8);
    chk("s7_drop",  32'(stat_drop),  32'd1);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      chk("s3_order", 32'(bus.out_y), 32'h100 + 32'(i));
      idle(1'b1);
    end
    chk("s3_drained", 32'(empty), 32'd1);

    // Full with simultaneous push/pop
    step(1'b1, 1'b0, 9'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      y = 9'h010 + 9'(i);
      step(1'b1, 1'b1, y, 4'(i), 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 9'h055, 4'h5, 1'b1, 1'b0);
    chk("s4_ovf", 32'(ovf_err), 32'd0);
    chk("s4_count", 32'(count), 32'd8);
    for (int i = 0; i < DEPTH - 1; i++) idle(1'b1);
    chk("s4_last", 32'(bus.out_y), 32'h055);
    idle(1'b1);

    // Streaming through wrap, then reset mid-operation
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 9'($urandom), 4'($urandom), 1'b1, 1'b0);
      chk("s5_cnt_le1", 32'(count <= 1), 32'd1);
    end
    idle(1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 9'(i + 1), 4'(i), 1'b0, 1'b0);
    step(1'b0, 1'b0, 9'h0, 4'h0, 1'b0, 1'b0);
    chk("s5_rst_empty", 32'(empty), 32'd1);
    step(1'b1, 1'b1, 9'h1C3, 4'h3, 1'b0, 1'b0);
    chk("s5_after_rst", 32'(bus.out_y), 32'h1C3);
    idle(1'b1);

    // Error clear race
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 9'($urandom), 4'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b1, 9'h077, 4'h7, 1'b0, 1'b1);
    chk("s6_set_wins", 32'(ovf_err), 32'd1);
    step(1'b1, 1'b0, 9'h0, 4'h0, 1'b0, 1'b1);
    chk("s6_clear", 32'(ovf_err), 32'd0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(99) != 0), ($urandom_range(3) != 0),
           9'($urandom), 4'($urandom), ($urandom_range(2) == 0),
           ($urandom_range(15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
